// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave with C_NUM_REGS shadowed control registers; one COMMIT write moves every pending
// shadow to the active outputs in the same cycle, with a one-cycle update strobe per register.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0108F800,
  parameter logic [31:0] C_HIGHADDR   = 32'h0108F8FF,
  parameter int unsigned C_OPB_AWIDTH = 32,
  parameter int unsigned C_OPB_DWIDTH = 32,
  parameter int unsigned C_NUM_REGS   = 8,
  parameter int unsigned C_REG_WIDTH  = 32,
  parameter logic [31:0] C_RESET_VAL  = 32'h0,
  parameter bit          C_SHADOWED   = 1'b1
) (
  input  logic                                OPB_Clk,
  input  logic                                OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]             OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]           OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]             OPB_DBus,
  input  logic                                OPB_RNW,
  input  logic                                OPB_select,
  input  logic                                OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]             Sl_DBus,
  output logic                                Sl_xferAck,
  output logic                                Sl_errAck,
  output logic                                Sl_retry,
  output logic                                Sl_toutSup,
  output logic [C_NUM_REGS*C_REG_WIDTH-1:0]   user_data_out,
  output logic [C_NUM_REGS-1:0]               user_update
);

  localparam int unsigned WordW = C_OPB_AWIDTH - 2;
  localparam logic [C_REG_WIDTH-1:0] ResetVal = C_RESET_VAL[C_REG_WIDTH-1:0];

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  logic [0:0]              state_q, state_d;
  logic [WordW-1:0]        word_q;
  logic [31:0]             wdata_q;
  logic [3:0]              be_q;
  logic                    rnw_q;
  logic [C_REG_WIDTH-1:0]  shadow_q [C_NUM_REGS];
  logic [C_REG_WIDTH-1:0]  shadow_d [C_NUM_REGS];
  logic [C_REG_WIDTH-1:0]  active_q [C_NUM_REGS];
  logic [C_REG_WIDTH-1:0]  active_d [C_NUM_REGS];
  logic [C_NUM_REGS-1:0]   pending_q, pending_d;
  logic [C_NUM_REGS-1:0]   update_q, update_d;
  logic                    auto_q, auto_d;

  logic [C_OPB_AWIDTH-1:0] abus, offset;
  logic [31:0]             dbus;
  logic [3:0]              be;
  logic                    in_range, start, auto_eff, is_ctrl, wr_en;
  logic [31:0]             rdata;
  logic                    unused_ok;

  // Numeric views of the big-endian bus: bit i of these is DBus[31-i]; be[j] covers byte j.
  assign abus     = OPB_ABus;
  assign dbus     = OPB_DBus;
  assign be       = OPB_BE;
  assign offset   = abus - C_OPB_AWIDTH'(C_BASEADDR);
  assign in_range = (abus >= C_OPB_AWIDTH'(C_BASEADDR)) && (abus <= C_OPB_AWIDTH'(C_HIGHADDR));
  assign start    = (state_q == StIdle) && OPB_select && in_range && !Sl_xferAck;

  assign Sl_xferAck = (state_q == StAck);
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign auto_eff = C_SHADOWED ? auto_q : 1'b1;
  assign is_ctrl  = (word_q == WordW'(C_NUM_REGS));
  assign wr_en    = Sl_xferAck && !rnw_q;
  assign unused_ok = ^{OPB_seqAddr, offset[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  en);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (en[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  always_comb begin
    state_d = StIdle;
    if (start) state_d = StAck;
  end

  always_comb begin
    logic [31:0] merged;
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    update_d  = '0;
    auto_d    = auto_q;
    merged    = '0;
    if (wr_en) begin
      if (is_ctrl && be_q[0]) begin
        if (C_SHADOWED) auto_d = wdata_q[1];
        if (wdata_q[0]) begin
          for (int k = 0; k < int'(C_NUM_REGS); k++) begin
            if (pending_q[k]) begin
              active_d[k]  = shadow_q[k];
              update_d[k]  = 1'b1;
              pending_d[k] = 1'b0;
            end
          end
        end
      end
      for (int k = 0; k < int'(C_NUM_REGS); k++) begin
        if (word_q == WordW'(k)) begin
          merged      = merge_bytes(32'(shadow_q[k]), wdata_q, be_q);
          shadow_d[k] = merged[C_REG_WIDTH-1:0];
          if (auto_eff) begin
            active_d[k]  = merged[C_REG_WIDTH-1:0];
            update_d[k]  = 1'b1;
            pending_d[k] = 1'b0;
          end else begin
            pending_d[k] = 1'b1;
          end
        end
      end
    end
  end

  // Reads always see the shadow copy so software can verify staged values before committing.
  always_comb begin
    rdata = '0;
    if (is_ctrl) rdata[1] = auto_eff;
    for (int k = 0; k < int'(C_NUM_REGS); k++) begin
      if (word_q == WordW'(k)) rdata = 32'(shadow_q[k]);
    end
  end

  assign Sl_DBus = (Sl_xferAck && rnw_q) ? rdata : '0;

  always_comb begin
    user_data_out = '0;
    for (int k = 0; k < int'(C_NUM_REGS); k++) begin
      user_data_out[k*C_REG_WIDTH +: C_REG_WIDTH] = active_q[k];
    end
  end

  assign user_update = update_q;

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_q   <= StIdle;
      word_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      rnw_q     <= 1'b0;
      pending_q <= '0;
      update_q  <= '0;
      auto_q    <= 1'b0;
      for (int k = 0; k < int'(C_NUM_REGS); k++) begin
        shadow_q[k] <= ResetVal;
        active_q[k] <= ResetVal;
      end
    end else begin
      state_q <= state_d;
      if (start) begin
        word_q  <= offset[C_OPB_AWIDTH-1:2];
        wdata_q <= dbus;
        be_q    <= be;
        rnw_q   <= OPB_RNW;
      end
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      update_q  <= update_d;
      auto_q    <= auto_d;
    end
  end

endmodule
